// File: rtl/alu_defs.sv
// Opcode constants shared between alu32 and its downstream result buffer,
// plus the packed layout of one buffered result entry.
package alu_defs;

  localparam int RESULT_ENTRY_W = 38;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_NOR = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [31:0] data;
    logic        overflow;
    logic        zero;
    logic        negative;
    logic [2:0]  control;
  } result_entry_t;

  // Only arithmetic opcodes carry a meaningful overflow indication.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. Full/empty come from an occupancy counter, so
// equal pointers never make full and empty ambiguous.
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the head is masked while
  // empty, so stale contents are never observable and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/alu32_result_buffer.sv
// Buffers alu32 results for a stalling consumer; tracks a sticky arithmetic
// overflow flag and a wrapping count of delivered results.
module alu32_result_buffer
  import alu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic [2:0]  alu_control,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_overflow,
  output logic        out_zero,
  output logic        out_negative,
  output logic [2:0]  out_control,
  output logic        sticky_overflow,
  input  logic        clear_sticky,
  output logic [15:0] result_count
);

  result_entry_t w_entry_in;
  result_entry_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push_fire;
  logic          w_pop_fire;
  logic          w_set_sticky;
  logic          r_sticky;
  logic [15:0]   r_result_count;

  assign w_entry_in = '{data: alu_out, overflow: alu_overflow, zero: alu_zero,
                        negative: alu_negative, control: alu_control};

  sync_fifo #(
    .WIDTH (RESULT_ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (in_valid),
    .i_wdata (w_entry_in),
    .i_pop   (out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready     = !w_full;
  assign out_valid    = !w_empty;
  assign w_push_fire  = in_valid && !w_full;
  assign w_pop_fire   = out_ready && !w_empty;
  assign w_set_sticky = w_push_fire && alu_overflow && is_arith(alu_control);

  assign out_data     = w_head.data;
  assign out_overflow = w_head.overflow;
  assign out_zero     = w_head.zero;
  assign out_negative = w_head.negative;
  assign out_control  = w_head.control;

  // A qualifying push in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sticky       <= 1'b0;
      r_result_count <= '0;
    end else begin
      if (w_set_sticky)      r_sticky <= 1'b1;
      else if (clear_sticky) r_sticky <= 1'b0;
      if (w_pop_fire) r_result_count <= r_result_count + 16'd1;
    end
  end

  assign sticky_overflow = r_sticky;
  assign result_count    = r_result_count;

endmodule

// File: tb/tb_alu32_result_buffer.sv
// Directed self-checking bench for alu32_result_buffer.
module tb_alu32_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_negative;
  logic [2:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_zero;
  logic        out_negative;
  logic [2:0]  out_control;
  logic        sticky_overflow;
  logic        clear_sticky;
  logic [15:0] result_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu32_result_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_out         (alu_out),
    .alu_overflow    (alu_overflow),
    .alu_zero        (alu_zero),
    .alu_negative    (alu_negative),
    .alu_control     (alu_control),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_overflow    (out_overflow),
    .out_zero        (out_zero),
    .out_negative    (out_negative),
    .out_control     (out_control),
    .sticky_overflow (sticky_overflow),
    .clear_sticky    (clear_sticky),
    .result_count    (result_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] c,
                       input logic ov, input logic z, input logic n);
    in_valid     = v;
    alu_out      = d;
    alu_control  = c;
    alu_overflow = ov;
    alu_zero     = z;
    alu_negative = n;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n      = 1'b0;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    idle();
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sticky", sticky_overflow, 0);
    check("rst_count", result_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_control", out_control, 0);

    // Single push, held by consumer, then popped
    drive(1'b1, 32'd12, 3'd2, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 12);
    check("single_ctrl", out_control, 2);
    check("single_in_ready", in_ready, 1);
    check("single_count", result_count, 0);
    step();
    check("single_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", result_count, 1);
    check("single_pop_valid", out_valid, 0);

    // Sticky set by ADD overflow; cleared alongside an XOR overflow push
    drive(1'b1, 32'hFFFF_FFFE, 3'd2, 1'b1, 1'b0, 1'b1);
    step();
    check("sticky_add_set", sticky_overflow, 1);
    drive(1'b1, 32'h0000_0005, 3'd7, 1'b1, 1'b1, 1'b1);
    clear_sticky = 1'b1;
    step();
    idle();
    clear_sticky = 1'b0;
    check("sticky_xor_clear", sticky_overflow, 0);
    step();
    check("sticky_stays_clear", sticky_overflow, 0);
    check("add_head_data", out_data, 32'hFFFF_FFFE);
    check("add_head_ovf", out_overflow, 1);
    check("add_head_neg", out_negative, 1);
    check("add_head_zero", out_zero, 0);
    out_ready = 1'b1;
    step();
    check("xor_head_data", out_data, 5);
    check("xor_head_ctrl", out_control, 7);
    check("xor_head_zero_raw", out_zero, 1);
    check("xor_head_neg", out_negative, 1);
    step();
    out_ready = 1'b0;
    check("after_sticky_count", result_count, 3);
    check("after_sticky_empty", out_valid, 0);

    // Fill to full; fifth push must be dropped
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 3'd5, 1'b0, 1'b0, 1'b0);
      step();
      if (i <= 3) check($sformatf("fill_in_ready_%0d", i), in_ready, 1);
      else        check($sformatf("fill_in_ready_%0d", i), in_ready, 0);
    end
    idle();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_valid_%0d", i), out_valid, 1);
      check($sformatf("drain_data_%0d", i), out_data, 32'(i));
      step();
      if (i == 1) check("full_pop_in_ready", in_ready, 1);
    end
    check("drain_empty", out_valid, 0);
    check("drain_count", result_count, 7);
    step();
    out_ready = 1'b0;
    check("empty_pop_ignored", result_count, 7);

    // Steady state: two entries buffered, push and pop together for 10 cycles
    drive(1'b1, 32'd100, 3'd2, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd101, 3'd2, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(102 + i), 3'd3, 1'b0, 1'b0, 1'b0);
      check($sformatf("steady_data_%0d", i), out_data, 32'(100 + i));
      step();
    end
    idle();
    check("steady_count", result_count, 17);
    check("steady_data_110", out_data, 110);
    step();
    check("steady_data_111", out_data, 111);
    step();
    out_ready = 1'b0;
    check("steady_drained", out_valid, 0);
    check("steady_final_count", result_count, 19);

    // Set wins over clear in the same cycle
    drive(1'b1, 32'h8000_0000, 3'd3, 1'b1, 1'b0, 1'b1);
    clear_sticky = 1'b1;
    step();
    idle();
    check("set_beats_clear", sticky_overflow, 1);
    step();
    clear_sticky = 1'b0;
    check("clear_alone", sticky_overflow, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("sub_pop_count", result_count, 20);

    // Reset mid-operation with three entries buffered
    drive(1'b1, 32'hAAAA_0001, 3'd2, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_0002, 3'd4, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_0003, 3'd6, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    check("pre_reset_sticky", sticky_overflow, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_count", result_count, 0);
    check("mid_rst_sticky", sticky_overflow, 0);
    check("mid_rst_data", out_data, 0);
    drive(1'b1, 32'hF0F0_F0F0, 3'd5, 1'b0, 1'b0, 1'b0);
    step();
    check("post_rst_first", out_data, 32'hF0F0_F0F0);
    check("post_rst_valid", out_valid, 1);

    // result_count wraps 0xFFFF -> 0x0000 under continuous push/pop
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check("count_at_ffff", result_count, 16'hFFFF);
    step();
    check("count_wrap", result_count, 0);
    idle();
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
